// File: rtl/cmul_arb_pkg.sv
// cmul_arb_pkg: shared FFT widths and requester count for the complex multiplier arbiter
package cmul_arb_pkg;
  localparam int BFLY = 10;
  localparam int TW = 9;
  localparam int WIDTH = BFLY + TW;
  localparam int NREQ = 2;
endpackage

// File: rtl/cmul_arb_cmul.sv
// cmul: combinational signed complex multiply, full product width, wraps without saturation
module cmul #(
  parameter int BFLY = cmul_arb_pkg::BFLY,
  parameter int TW = cmul_arb_pkg::TW,
  parameter int WIDTH = BFLY + TW
) (
  input  logic signed [BFLY-1:0]  re_i,
  input  logic signed [BFLY-1:0]  im_i,
  input  logic signed [TW-1:0]    tw_re_i,
  input  logic signed [TW-1:0]    tw_im_i,
  output logic signed [WIDTH-1:0] re_o,
  output logic signed [WIDTH-1:0] im_o
);
  logic signed [WIDTH-1:0] a, b, c, d;
  assign a = WIDTH'(re_i);
  assign b = WIDTH'(im_i);
  assign c = WIDTH'(tw_re_i);
  assign d = WIDTH'(tw_im_i);
  assign re_o = a * c - b * d;
  assign im_o = b * c + a * d;
endmodule

// File: rtl/cmul_arb.sv
// cmul_arb: round-robin arbiter sharing one two-stage complex multiplier between two requesters
module cmul_arb
  import cmul_arb_pkg::NREQ;
#(
  parameter int BFLY = cmul_arb_pkg::BFLY,
  parameter int TW = cmul_arb_pkg::TW,
  parameter int WIDTH = BFLY + TW
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NREQ-1:0]         req_valid,
  output logic [NREQ-1:0]         req_ready,
  input  logic signed [BFLY-1:0]  req0_re,
  input  logic signed [BFLY-1:0]  req0_im,
  input  logic signed [TW-1:0]    req0_tw_re,
  input  logic signed [TW-1:0]    req0_tw_im,
  input  logic signed [BFLY-1:0]  req1_re,
  input  logic signed [BFLY-1:0]  req1_im,
  input  logic signed [TW-1:0]    req1_tw_re,
  input  logic signed [TW-1:0]    req1_tw_im,
  input  logic                    flush,
  output logic                    out_valid,
  output logic                    out_id,
  output logic signed [WIDTH-1:0] out_re,
  output logic signed [WIDTH-1:0] out_im,
  output logic [1:0]              inflight
);
  logic last_q, last_d, fire, gnt_id;
  logic s1_v_q, s1_id_q, s2_v_q, s2_v_d;
  logic signed [BFLY-1:0] s1_re_q, s1_im_q;
  logic signed [TW-1:0] s1_tr_q, s1_ti_q;
  logic signed [WIDTH-1:0] p_re, p_im;
  // last_q=1 means requester 1 won last, so requester 0 takes the next tie
  always_comb begin
    req_ready = (flush || !rst_n) ? '0 : (&req_valid) ? (last_q ? 2'b01 : 2'b10) : req_valid;
    fire = |(req_valid & req_ready);
    gnt_id = req_ready[1];
    last_d = fire ? gnt_id : last_q;
    s2_v_d = s1_v_q && !flush;
  end
  cmul #(.BFLY(BFLY), .TW(TW), .WIDTH(WIDTH)) u_cmul (
    .re_i(s1_re_q), .im_i(s1_im_q), .tw_re_i(s1_tr_q), .tw_im_i(s1_ti_q),
    .re_o(p_re), .im_o(p_im)
  );
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q <= 1'b1;
      s1_v_q <= 1'b0;
      s2_v_q <= 1'b0;
      s1_id_q <= 1'b0;
      s1_re_q <= '0;
      s1_im_q <= '0;
      s1_tr_q <= '0;
      s1_ti_q <= '0;
      out_id <= 1'b0;
      out_re <= '0;
      out_im <= '0;
    end else begin
      last_q <= last_d;
      s1_v_q <= fire;
      s2_v_q <= s2_v_d;
      if (fire) begin
        s1_id_q <= gnt_id;
        s1_re_q <= gnt_id ? req1_re : req0_re;
        s1_im_q <= gnt_id ? req1_im : req0_im;
        s1_tr_q <= gnt_id ? req1_tw_re : req0_tw_re;
        s1_ti_q <= gnt_id ? req1_tw_im : req0_tw_im;
      end
      // outputs only move when a result is presented, so they hold while idle
      if (s2_v_d) begin
        out_id <= s1_id_q;
        out_re <= p_re;
        out_im <= p_im;
      end
    end
  end
  assign out_valid = s2_v_q;
  assign inflight = {1'b0, s1_v_q} + {1'b0, s2_v_q};
endmodule

// File: tb/tb_cmul_arb.sv
// tb_cmul_arb: randomized and directed checks of cmul_arb against a queue-based reference model
module tb_cmul_arb;
  logic clk = 1'b0, rst_n = 1'b1, flush = 1'b0;
  logic [1:0] req_valid = 2'b00, req_ready, inflight;
  logic signed [9:0] op_re [2], op_im [2];
  logic signed [8:0] op_tr [2], op_ti [2];
  logic out_valid, out_id;
  logic signed [18:0] out_re, out_im;

  always #5 clk = ~clk;

  cmul_arb dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req0_re(op_re[0]), .req0_im(op_im[0]), .req0_tw_re(op_tr[0]), .req0_tw_im(op_ti[0]),
    .req1_re(op_re[1]), .req1_im(op_im[1]), .req1_tw_re(op_tr[1]), .req1_tw_im(op_ti[1]),
    .flush(flush), .out_valid(out_valid), .out_id(out_id),
    .out_re(out_re), .out_im(out_im), .inflight(inflight)
  );

  typedef struct {logic id; logic signed [18:0] re; logic signed [18:0] im; int t;} ent_t;
  ent_t pend[$];
  int cyc = 0, checks = 0, errors = 0;
  logic m_last = 1'b1;
  logic exp_valid, exp_id;
  logic signed [18:0] exp_re, exp_im;
  logic [1:0] exp_ready, exp_infl, obs_ready;

  function automatic logic [1:0] pick(input logic [1:0] v, input logic f, input logic l);
    int w;
    if (f || v == 2'b00) return 2'b00;
    w = (v == 2'b11) ? int'(!l) : int'(v[1]);
    return 2'(1 << w);
  endfunction

  function automatic logic signed [18:0] prod_re(input int i);
    return 19'(int'(op_re[i]) * int'(op_tr[i]) - int'(op_im[i]) * int'(op_ti[i]));
  endfunction

  function automatic logic signed [18:0] prod_im(input int i);
    return 19'(int'(op_im[i]) * int'(op_tr[i]) + int'(op_re[i]) * int'(op_ti[i]));
  endfunction

  task automatic model_reset();
    pend.delete();
    m_last = 1'b1;
    exp_valid = 1'b0;
    exp_id = 1'b0;
    exp_re = '0;
    exp_im = '0;
    exp_infl = 2'd0;
  endtask

  task automatic randomize_ops();
    for (int i = 0; i < 2; i++) begin
      op_re[i] = 10'($urandom);
      op_im[i] = 10'($urandom);
      op_tr[i] = 9'($urandom);
      op_ti[i] = 9'($urandom);
    end
  endtask

  // each accepted op is shown one edge after acceptance and leaves the model after that
  task automatic drive(input logic [1:0] v, input logic f);
    int i;
    req_valid = v;
    flush = f;
    #1;
    exp_ready = pick(v, f, m_last);
    obs_ready = req_ready;
    @(posedge clk);
    cyc++;
    if (f) pend.delete();
    while (pend.size() > 0 && pend[0].t < cyc - 1) void'(pend.pop_front());
    if (exp_ready != 2'b00) begin
      i = int'(exp_ready[1]);
      pend.push_back('{exp_ready[1], prod_re(i), prod_im(i), cyc});
      m_last = exp_ready[1];
    end
    exp_valid = pend.size() > 0 && pend[0].t == cyc - 1;
    if (exp_valid) begin
      exp_id = pend[0].id;
      exp_re = pend[0].re;
      exp_im = pend[0].im;
    end
    exp_infl = 2'(pend.size());
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    req_valid = 2'b00;
    flush = 1'b0;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      op_re[i] = '0; op_im[i] = '0; op_tr[i] = '0; op_ti[i] = '0;
    end
    #1 rst_n = 1'b0;
    req_valid = 2'b11;
    #3;
    checks++;
    if (req_ready !== 2'b00) begin
      errors++;
      $display("FAIL reset_ready got %b want 00", req_ready);
    end
    checks++;
    if ({out_valid, out_id, out_re, out_im, inflight} !== 42'd0) begin
      errors++;
      $display("FAIL reset_outputs got v=%b id=%b re=%0d im=%0d infl=%0d want all 0", out_valid, out_id, out_re, out_im, inflight);
    end
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    req_valid = 2'b00;
  endtask

  task automatic test_single();
    op_re[0] = 10'sd3; op_im[0] = 10'sd4; op_tr[0] = 9'sd5; op_ti[0] = 9'sd6;
    drive(2'b01, 1'b0);
    checks++;
    if (obs_ready !== 2'b01 || inflight !== 2'd1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL single_accept got ready=%b infl=%0d v=%b want ready=01 infl=1 v=0", obs_ready, inflight, out_valid);
    end
    drive(2'b00, 1'b0);
    checks++;
    if (out_valid !== 1'b1 || out_id !== 1'b0 || out_re !== -19'sd9 || out_im !== 19'sd38 || inflight !== 2'd1) begin
      errors++;
      $display("FAIL single_result got v=%b id=%b re=%0d im=%0d infl=%0d want v=1 id=0 re=-9 im=38 infl=1", out_valid, out_id, out_re, out_im, inflight);
    end
    drive(2'b00, 1'b0);
    checks++;
    if (out_valid !== 1'b0 || inflight !== 2'd0 || out_re !== -19'sd9 || out_im !== 19'sd38) begin
      errors++;
      $display("FAIL single_hold got v=%b infl=%0d re=%0d im=%0d want v=0 infl=0 re=-9 im=38", out_valid, inflight, out_re, out_im);
    end
  endtask

  task automatic test_back_to_back();
    logic [1:0] want;
    do_reset();
    for (int k = 0; k < 6; k++) begin
      randomize_ops();
      drive(k < 4 ? 2'b11 : 2'b00, 1'b0);
      want = (k % 2 == 0) ? 2'b01 : 2'b10;
      checks++;
      if (k < 4 && obs_ready !== want) begin
        errors++;
        $display("FAIL b2b_grant%0d got %b want %b", k, obs_ready, want);
      end
      checks++;
      if ({out_valid, out_id, out_re, out_im, inflight} !== {exp_valid, exp_id, exp_re, exp_im, exp_infl}
          || (k >= 1 && k <= 4 && (out_valid !== 1'b1 || out_id !== 1'((k - 1) % 2)))) begin
        errors++;
        $display("FAIL b2b_out%0d got v=%b id=%b re=%0d im=%0d infl=%0d want v=%b id=%b re=%0d im=%0d infl=%0d",
                 k, out_valid, out_id, out_re, out_im, inflight, exp_valid, exp_id, exp_re, exp_im, exp_infl);
      end
    end
  endtask

  task automatic test_extremes();
    do_reset();
    op_re[0] = -10'sd512; op_im[0] = -10'sd512; op_tr[0] = -9'sd256; op_ti[0] = 9'sd0;
    drive(2'b01, 1'b0);
    op_re[0] = 10'sd511; op_im[0] = 10'sd511; op_tr[0] = 9'sd255; op_ti[0] = 9'sd255;
    drive(2'b01, 1'b0);
    checks++;
    if (out_valid !== 1'b1 || out_re !== 19'sd131072 || out_im !== 19'sd131072) begin
      errors++;
      $display("FAIL extreme_neg got v=%b re=%0d im=%0d want v=1 re=131072 im=131072", out_valid, out_re, out_im);
    end
    drive(2'b00, 1'b0);
    checks++;
    if (out_valid !== 1'b1 || out_re !== 19'sd0 || out_im !== 19'sd260610) begin
      errors++;
      $display("FAIL extreme_pos got v=%b re=%0d im=%0d want v=1 re=0 im=260610", out_valid, out_re, out_im);
    end
  endtask

  task automatic test_flush();
    do_reset();
    randomize_ops();
    drive(2'b11, 1'b0);
    drive(2'b11, 1'b0);
    drive(2'b11, 1'b1);
    checks++;
    if (obs_ready !== 2'b00) begin
      errors++;
      $display("FAIL flush_ready got %b want 00", obs_ready);
    end
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (out_valid !== 1'b0 || inflight !== 2'd0) begin
        errors++;
        $display("FAIL flush_drain%0d got v=%b infl=%0d want v=0 infl=0", k, out_valid, inflight);
      end
      drive(2'b00, 1'b0);
    end
  endtask

  task automatic test_reset_midflight();
    do_reset();
    drive(2'b01, 1'b0);
    drive(2'b10, 1'b0);
    checks++;
    if (inflight !== 2'd2) begin
      errors++;
      $display("FAIL mid_inflight got %0d want 2", inflight);
    end
    req_valid = 2'b11;
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if ({out_valid, out_id, out_re, out_im, inflight, req_ready} !== 44'd0) begin
      errors++;
      $display("FAIL mid_reset got v=%b id=%b re=%0d im=%0d infl=%0d ready=%b want all 0", out_valid, out_id, out_re, out_im, inflight, req_ready);
    end
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    randomize_ops();
    drive(2'b11, 1'b0);
    checks++;
    if (obs_ready !== 2'b01 || out_valid !== 1'b0 || inflight !== 2'd1) begin
      errors++;
      $display("FAIL mid_release got ready=%b v=%b infl=%0d want ready=01 v=0 infl=1", obs_ready, out_valid, inflight);
    end
    drive(2'b00, 1'b0);
    checks++;
    if ({out_valid, out_id, out_re, out_im} !== {1'b1, 1'b0, exp_re, exp_im}) begin
      errors++;
      $display("FAIL mid_result got v=%b id=%b re=%0d im=%0d want v=1 id=0 re=%0d im=%0d", out_valid, out_id, out_re, out_im, exp_re, exp_im);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int k = 0; k < 400; k++) begin
      randomize_ops();
      drive(2'($urandom_range(0, 3)), $urandom_range(0, 9) == 0);
      checks++;
      if (obs_ready !== exp_ready) begin
        errors++;
        $display("FAIL rand_ready%0d got %b want %b", k, obs_ready, exp_ready);
      end
      checks++;
      if ({out_valid, out_id, out_re, out_im, inflight} !== {exp_valid, exp_id, exp_re, exp_im, exp_infl}) begin
        errors++;
        $display("FAIL rand_out%0d got v=%b id=%b re=%0d im=%0d infl=%0d want v=%b id=%b re=%0d im=%0d infl=%0d",
                 k, out_valid, out_id, out_re, out_im, inflight, exp_valid, exp_id, exp_re, exp_im, exp_infl);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_extremes();
    test_flush();
    test_reset_midflight();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
